pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Reset and lock sequencer for a parametrised PLL clock tree. Runs on the free-running PLL reference clock and drives PLL reset/power-down. Qualifies the asynchronous LOCKED flag and releases per-output-domain resets in a staggered order. Handles lock loss and lock timeout with automatic retry, so clock wrappers of the PLL/BUFG kind become self-recovering with N_OUT outputs.

Parameters:
N_OUT, 3, number of PLL output clock domains, each with its own reset output (1-6)
SYNC_STAGES, 2, flip-flops in the LOCKED synchroniser (>=2)
RST_HOLD_CYCLES, 16, cycles PLL_RST is held high per reset attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 65536, maximum cycles in WAIT_LOCK before a retry (>=2)
STAGGER_CYCLES, 8, cycles between successive OUT_RST bit releases (>=1)
CNT_W, 8, width of the retry/loss counters

Ports:
CLK  in  1  reference clock, the same net as the PLL CLKIN1 (200 MHz)
RST  in  1  asynchronous, active-high reset
ENABLE  in  1  1 = run PLL, 0 = power down
PLL_LOCKED  in  1  PLL LOCKED; asynchronous, synchronised internally
PLL_RST  out  1  to PLL RST
PLL_PWRDWN  out  1  to PLL PWRDWN
OUT_RST  out  N_OUT  active-high per-domain reset; consumers re-synchronise
READY  out  1  all domains released, lock good
TIMEOUT_ERR  out  1  sticky; a lock timeout occurred
RETRY_CNT  out  CNT_W  saturating count of reset attempts after the first

Behaviour:
- Reset values: state OFF, PLL_PWRDWN=1, PLL_RST=1, OUT_RST=all 1, READY=0, TIMEOUT_ERR=0, RETRY_CNT=0, synchroniser all 0. All outputs are registered.
- lock_s is PLL_LOCKED delayed through SYNC_STAGES flops.
- Priority in every state except OFF:
  - ENABLE=0 has the highest priority: go to OFF next cycle, OUT_RST=all 1, READY=0.
  - lock loss comes next.
  - timer expiry comes last.
- OFF: PWRDWN=1, PLL_RST=1. ENABLE=1 -> PLL_RESET, timer cleared.
- PLL_RESET: PWRDWN=0, PLL_RST=1 for exactly RST_HOLD_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK: PLL_RST=0.
  - lock_s=1 -> STABILIZE next cycle.
  - Timer reaches LOCK_TIMEOUT_CYCLES with lock_s=0 -> TIMEOUT_ERR=1, RETRY_CNT+1 (saturating), -> PLL_RESET.
- STABILIZE: counts consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK with the timeout timer restarted.
  - After LOCK_STABLE_CYCLES cycles -> RELEASE.
- RELEASE: OUT_RST[k] deasserts (k+1)*STAGGER_CYCLES cycles after entry; bit 0 first, ascending.
  - In the cycle OUT_RST[N_OUT-1] deasserts, state becomes RUN and READY=1.
  - lock_s=0 during RELEASE -> LOST.
- RUN: hold. lock_s=0 -> LOST.
- LOST: single cycle. OUT_RST=all 1, READY=0, RETRY_CNT+1 (saturating), -> PLL_RESET.
- Once OUT_RST bits deassert they stay deasserted until OFF or LOST. OUT_RST reasserts all bits in the same cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- TIMEOUT_ERR clears only on RST.
- RST asserted mid-sequence immediately forces all reset values (asynchronous).
- Timer and counter widths are sized by $clog2 of the largest parameter.

Optional Feature:
PLLSUP_LOSS_CNT_EN:
- Defined: adds port LOSS_CNT out CNT_W. It counts RUN/RELEASE -> LOST transitions only, saturates, resets to 0, and increments in the same cycle as RETRY_CNT.
- Undefined: the port and its logic are absent. RETRY_CNT behaviour is unchanged.

Test Plan:
Bench parameters: N_OUT=3, SYNC_STAGES=2, RST_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, STAGGER_CYCLES=2.
1. Normal bring-up: PLL_LOCKED=1 held, ENABLE=1, RST released.
   -> PLL_RST high for 4 cycles after PWRDWN falls.
   -> OUT_RST[0], [1], [2] fall 2 cycles apart.
   -> READY=1 exactly 19 cycles after entering PLL_RESET. RETRY_CNT=0, TIMEOUT_ERR=0.
2. Timeout: PLL_LOCKED=0 held.
   -> After 32 WAIT_LOCK cycles, TIMEOUT_ERR=1, RETRY_CNT=1, PLL_RST high again for 4 cycles.
   -> After 3 timeouts RETRY_CNT=3. OUT_RST stays 3'b111 throughout.
3. Lock glitch in STABILIZE: drop PLL_LOCKED for 1 cycle after 5 stable cycles.
   -> Returns to WAIT_LOCK; needs a further 8 consecutive lock cycles. No OUT_RST change, RETRY_CNT=0.
4. Lock loss in RUN: drop PLL_LOCKED while READY=1.
   -> 3 cycles later (2 sync + LOST), OUT_RST=3'b111, READY=0, RETRY_CNT=1 (LOSS_CNT=1 if enabled).
   -> Full re-sequence follows.
5. ENABLE=0 during RELEASE with OUT_RST=3'b110.
   -> Next cycle OUT_RST=3'b111, PWRDWN=1, PLL_RST=1.
   -> Re-enable gives a normal 19-cycle bring-up.
6. Saturation: CNT_W=2 with 5 timeouts -> RETRY_CNT=3. Async RST mid-RELEASE -> all reset values without a clock edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/power-down sequencer with LOCKED qualification,
// staggered per-domain reset release, lock-loss and lock-timeout retry.
// Ports: CLK/RST (async, active-high) reference clock and reset; ENABLE runs the PLL;
//   PLL_LOCKED async lock flag; PLL_RST/PLL_PWRDWN drive the PLL; OUT_RST[N_OUT]
//   per-domain resets; READY all released; TIMEOUT_ERR sticky; RETRY_CNT saturating.
// Option: define PLLSUP_LOSS_CNT_EN to add LOSS_CNT (RUN/RELEASE lock-loss count).
module pll_lock_supervisor #(
   parameter int N_OUT               = 3,
   parameter int SYNC_STAGES         = 2,
   parameter int RST_HOLD_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int STAGGER_CYCLES      = 8,
   parameter int CNT_W               = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENABLE,
   input  logic             PLL_LOCKED,
   output logic             PLL_RST,
   output logic             PLL_PWRDWN,
   output logic [N_OUT-1:0] OUT_RST,
   output logic             READY,
   output logic             TIMEOUT_ERR,
`ifdef PLLSUP_LOSS_CNT_EN
   output logic [CNT_W-1:0] LOSS_CNT,
`endif
   output logic [CNT_W-1:0] RETRY_CNT
);

   localparam int REL_CYCLES = N_OUT * STAGGER_CYCLES;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAXC = max2(max2(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES),
                              max2(LOCK_TIMEOUT_CYCLES, REL_CYCLES));
   localparam int TW = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      S_OFF,
      S_PLL_RESET,
      S_WAIT_LOCK,
      S_STABILIZE,
      S_RELEASE,
      S_RUN,
      S_LOST
   } state_t;

   state_t                 state;
   logic [TW-1:0]          timer;
   logic [TW-1:0]          t_next;
   logic [SYNC_STAGES-1:0] sync;
   logic                   lock_s;

   assign lock_s = sync[SYNC_STAGES-1];
   assign t_next = timer + 1'b1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= S_OFF;
         timer       <= '0;
         sync        <= '0;
         PLL_RST     <= 1'b1;
         PLL_PWRDWN  <= 1'b1;
         OUT_RST     <= '1;
         READY       <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         RETRY_CNT   <= '0;
`ifdef PLLSUP_LOSS_CNT_EN
         LOSS_CNT    <= '0;
`endif
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], PLL_LOCKED};
         if (state != S_OFF && !ENABLE) begin
            state      <= S_OFF;
            timer      <= '0;
            PLL_RST    <= 1'b1;
            PLL_PWRDWN <= 1'b1;
            OUT_RST    <= '1;
            READY      <= 1'b0;
         end else begin
            unique case (state)
               S_OFF: begin
                  if (ENABLE) begin
                     state      <= S_PLL_RESET;
                     timer      <= '0;
                     PLL_PWRDWN <= 1'b0;
                     PLL_RST    <= 1'b1;
                  end
               end
               S_PLL_RESET: begin
                  if (timer == TW'(RST_HOLD_CYCLES - 1)) begin
                     state   <= S_WAIT_LOCK;
                     timer   <= '0;
                     PLL_RST <= 1'b0;
                  end else begin
                     timer <= t_next;
                  end
               end
               S_WAIT_LOCK: begin
                  if (lock_s) begin
                     state <= S_STABILIZE;
                     timer <= '0;
                  end else if (timer == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                     state       <= S_PLL_RESET;
                     timer       <= '0;
                     PLL_RST     <= 1'b1;
                     TIMEOUT_ERR <= 1'b1;
                     RETRY_CNT   <= sat_inc(RETRY_CNT);
                  end else begin
                     timer <= t_next;
                  end
               end
               S_STABILIZE: begin
                  if (!lock_s) begin
                     state <= S_WAIT_LOCK;
                     timer <= '0;
                  end else if (timer == TW'(LOCK_STABLE_CYCLES - 1)) begin
                     state <= S_RELEASE;
                     timer <= '0;
                  end else begin
                     timer <= t_next;
                  end
               end
               S_RELEASE, S_RUN: begin
                  if (!lock_s) begin
                     state     <= S_LOST;
                     timer     <= '0;
                     OUT_RST   <= '1;
                     READY     <= 1'b0;
                     RETRY_CNT <= sat_inc(RETRY_CNT);
`ifdef PLLSUP_LOSS_CNT_EN
                     LOSS_CNT  <= sat_inc(LOSS_CNT);
`endif
                  end else if (state == S_RELEASE) begin
                     // timer counts cycles since entry; bit k drops at (k+1)*STAGGER
                     timer <= t_next;
                     for (int k = 0; k < N_OUT; k++) begin
                        if (t_next == TW'((k + 1) * STAGGER_CYCLES))
                           OUT_RST[k] <= 1'b0;
                     end
                     if (t_next == TW'(REL_CYCLES)) begin
                        state <= S_RUN;
                        timer <= '0;
                        READY <= 1'b1;
                     end
                  end
               end
               S_LOST: begin
                  state   <= S_PLL_RESET;
                  timer   <= '0;
                  PLL_RST <= 1'b1;
               end
               default: begin
                  state <= S_OFF;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed scoreboard bench for pll_lock_supervisor.
// Ports: none; drives CLK/RST/ENABLE/PLL_LOCKED and checks all outputs.
module tb_pll_lock_supervisor;

   localparam int N_OUT = 3;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             enable = 1'b0;
   logic             pll_locked = 1'b0;
   logic             pll_rst;
   logic             pll_pwrdwn;
   logic [N_OUT-1:0] out_rst;
   logic             ready;
   logic             timeout_err;
   logic [CNT_W-1:0] retry_cnt;
`ifdef PLLSUP_LOSS_CNT_EN
   logic [CNT_W-1:0] loss_cnt;
`endif

   always #5 clk = ~clk;

   pll_lock_supervisor #(
      .N_OUT(N_OUT), .SYNC_STAGES(2), .RST_HOLD_CYCLES(4),
      .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32),
      .STAGGER_CYCLES(2), .CNT_W(CNT_W)
   ) dut (
      .CLK(clk), .RST(rst), .ENABLE(enable), .PLL_LOCKED(pll_locked),
      .PLL_RST(pll_rst), .PLL_PWRDWN(pll_pwrdwn), .OUT_RST(out_rst),
      .READY(ready), .TIMEOUT_ERR(timeout_err),
`ifdef PLLSUP_LOSS_CNT_EN
      .LOSS_CNT(loss_cnt),
`endif
      .RETRY_CNT(retry_cnt)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check_next(input logic [31:0] obs);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL sb_empty observed=%0d required=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            fails++;
            $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic lk);
      rst = 1'b1;
      enable = 1'b1;
      pll_locked = lk;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // returns at the first sample where the PLL_RESET phase has just begun
   task automatic wait_start(output int ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (pll_rst && !pll_pwrdwn) begin
            ok = 1;
            return;
         end
         tick();
      end
   endtask

   task automatic bring(input int glitch_at, output int t_fall,
                        output int t0, output int t1, output int t2,
                        output int t_rdy);
      int ok;
      t_fall = -1; t0 = -1; t1 = -1; t2 = -1; t_rdy = -1;
      wait_start(ok);
      if (ok == 0) return;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (t_fall < 0 && !pll_rst)    t_fall = i;
         if (t0 < 0 && !out_rst[0])     t0 = i;
         if (t1 < 0 && !out_rst[1])     t1 = i;
         if (t2 < 0 && !out_rst[2])     t2 = i;
         if (t_rdy < 0 && ready)        t_rdy = i;
         if (i == glitch_at)            pll_locked = 1'b0;
         else if (glitch_at >= 0 && i == glitch_at + 1) pll_locked = 1'b1;
      end
   endtask

   task automatic push_bringup(input string p, input int off);
      sb_push({p, "_pll_rst_fall"}, 4);
      sb_push({p, "_out0_fall"}, 15 + off);
      sb_push({p, "_out1_fall"}, 17 + off);
      sb_push({p, "_out2_fall"}, 19 + off);
      sb_push({p, "_ready_rise"}, 19 + off);
   endtask

   task automatic check_bringup(input int glitch_at);
      int tf, a, b, c, r;
      bring(glitch_at, tf, a, b, c, r);
      check_next(tf);
      check_next(a);
      check_next(b);
      check_next(c);
      check_next(r);
   endtask

   initial begin
      int ok, t_fall, t_rise, t_err, rises, retry_rise, retry110, all_set;
      logic prev_rst;

      // async reset state, sampled before any clock edge
      #2 rst = 1'b1;
      #1;
      sb_push("rst_pll_rst", 1);
      sb_push("rst_pwrdwn", 1);
      sb_push("rst_out_rst", 3'b111);
      sb_push("rst_ready", 0);
      sb_push("rst_timeout_err", 0);
      sb_push("rst_retry", 0);
      check_next(pll_rst);
      check_next(pll_pwrdwn);
      check_next(out_rst);
      check_next(ready);
      check_next(timeout_err);
      check_next(retry_cnt);
      tick();
      rst = 1'b0;
      tick(); tick(); tick();
      sb_push("off_hold_pwrdwn", 1);
      check_next(pll_pwrdwn);

      // normal bring-up
      do_reset(1'b1);
      push_bringup("t1", 0);
      check_bringup(-1);
      sb_push("t1_retry", 0);
      sb_push("t1_timeout_err", 0);
      check_next(retry_cnt);
      check_next(timeout_err);

      // single-cycle lock glitch inside STABILIZE adds 7 cycles
      do_reset(1'b1);
      push_bringup("t3", 7);
      check_bringup(8);
      sb_push("t3_retry", 0);
      check_next(retry_cnt);

      // lock loss in RUN
      pll_locked = 1'b0;
      tick(); tick();
      sb_push("t4_ready_before_lost", 1);
      check_next(ready);
      tick();
      sb_push("t4_out_rst", 3'b111);
      sb_push("t4_ready", 0);
      sb_push("t4_retry", 1);
      check_next(out_rst);
      check_next(ready);
      check_next(retry_cnt);
`ifdef PLLSUP_LOSS_CNT_EN
      sb_push("t4_loss_cnt", 1);
      check_next(loss_cnt);
`endif
      pll_locked = 1'b1;
      push_bringup("t4_reseq", 0);
      check_bringup(-1);

      // ENABLE drop during RELEASE
      do_reset(1'b1);
      wait_start(ok);
      for (int i = 0; i < 15; i++) tick();
      sb_push("t5_out_rst_mid", 3'b110);
      check_next(out_rst);
      enable = 1'b0;
      tick();
      sb_push("t5_out_rst_off", 3'b111);
      sb_push("t5_pwrdwn_off", 1);
      sb_push("t5_pll_rst_off", 1);
      sb_push("t5_ready_off", 0);
      check_next(out_rst);
      check_next(pll_pwrdwn);
      check_next(pll_rst);
      check_next(ready);
      enable = 1'b1;
      push_bringup("t5_reen", 0);
      check_bringup(-1);

      // repeated timeouts and counter saturation
      do_reset(1'b0);
      sb_push("t2_start", 1);
      sb_push("t2_pll_rst_fall", 4);
      sb_push("t2_pll_rst_rise", 36);
      sb_push("t2_err_rise", 36);
      sb_push("t2_retry_first", 1);
      sb_push("t2_retry_3", 3);
      sb_push("t2_out_rst_held", 1);
      sb_push("t2_timeouts", 5);
      sb_push("t6_retry_sat", 3);
      wait_start(ok);
      t_fall = -1; t_rise = -1; t_err = -1; rises = 0;
      retry_rise = -1; retry110 = -1; all_set = 1;
      prev_rst = 1'b1;
      for (int i = 1; i <= 185; i++) begin
         tick();
         if (t_fall < 0 && !pll_rst) t_fall = i;
         if (pll_rst && !prev_rst) begin
            rises++;
            if (rises == 1) begin
               t_rise = i;
               retry_rise = int'(retry_cnt);
            end
         end
         if (t_err < 0 && timeout_err) t_err = i;
         if (out_rst != 3'b111) all_set = 0;
         if (i == 110) retry110 = int'(retry_cnt);
         prev_rst = pll_rst;
      end
      check_next(ok);
      check_next(t_fall);
      check_next(t_rise);
      check_next(t_err);
      check_next(retry_rise);
      check_next(retry110);
      check_next(all_set);
      check_next(rises);
      check_next(retry_cnt);

      // async RST during RELEASE
      pll_locked = 1'b1;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (out_rst == 3'b110) begin
            ok = 1;
            break;
         end
         tick();
      end
      sb_push("t6_reach_release", 1);
      sb_push("t6_err_before", 1);
      check_next(ok);
      check_next(timeout_err);
      #3 rst = 1'b1;
      #1;
      sb_push("t6_pll_rst", 1);
      sb_push("t6_pwrdwn", 1);
      sb_push("t6_out_rst", 3'b111);
      sb_push("t6_ready", 0);
      sb_push("t6_timeout_err", 0);
      sb_push("t6_retry", 0);
      check_next(pll_rst);
      check_next(pll_pwrdwn);
      check_next(out_rst);
      check_next(ready);
      check_next(timeout_err);
      check_next(retry_cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
